// File: rtl/imem_pkg.sv
// imem_pkg: shared fetch-side types and constants.
// Used by the fetch sequencer and the address legality checker.
package imem_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] IMEM_SIZE_DEFAULT = 32'h8000;
  localparam logic [ADDR_W-1:0] WORD_STEP         = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_addr_legal.sv
// imem_addr_legal: combinational legality check for a memory word address.
// Ports: i_addr (byte address), o_legal (aligned and inside SIZE bytes).
module imem_addr_legal
  import imem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SIZE = IMEM_SIZE_DEFAULT
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_legal
);

  logic w_aligned;
  logic w_in_range;

  assign w_aligned  = (i_addr[1:0] == 2'b00);
  assign w_in_range = (i_addr <= SIZE - WORD_STEP);
  assign o_legal    = w_aligned & w_in_range;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer owning the PC in front of a 1-cycle IMEM.
// Ports: clk, rst_n, redirect_valid/redirect_pc, out_valid/out_ready/
// out_instr/out_pc to decode, fault, imem_address/imem_instruction.
// Build macro IMEM_BOUNDS_CHECK_EN: illegal fetch addresses trap into HALT.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SIZE     = IMEM_SIZE_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_cur_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_wrap_pc;
  logic [ADDR_W-1:0] w_addr;

  logic r_fault;
  logic w_fault_nxt;
  logic w_legal;
  logic w_redir;

  // The IMEM address must read RESET_PC while reset is held.
  assign w_redir = redirect_valid & rst_n;

  always_comb begin
    w_next_pc = r_cur_pc;
    if (w_redir) begin
      w_next_pc = redirect_pc;
    end else if (r_state == BOOT) begin
      w_next_pc = RESET_PC;
    end else if ((r_state == RUN) && out_ready) begin
      w_next_pc = r_cur_pc + WORD_STEP;
    end
  end

  imem_addr_legal #(
    .SIZE (SIZE)
  ) u_legal (
    .i_addr  (w_next_pc),
    .o_legal (w_legal)
  );

  assign w_wrap_pc =
    w_next_pc & (SIZE - 1) & ~(WORD_STEP - 1);

`ifdef IMEM_BOUNDS_CHECK_EN
  // Illegal target: keep re-reading the current word.
  assign w_addr = w_legal ? w_next_pc : r_cur_pc;
`else
  // Legal addresses pass unchanged; others wrap and align.
  assign w_addr = w_legal ? w_next_pc : w_wrap_pc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = r_fault;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (!w_legal) begin
      w_state_nxt = HALT;
      w_fault_nxt = 1'b1;
    end else
`endif
    if (w_redir) begin
      w_state_nxt = RUN;
      w_fault_nxt = 1'b0;
    end else if (r_state == BOOT) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BOOT;
      r_cur_pc <= RESET_PC;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_pc <= w_addr;
      r_fault  <= w_fault_nxt;
    end
  end

  assign imem_address = w_addr;
  assign out_valid    = (r_state == RUN) & ~w_redir;
  assign out_instr    = imem_instruction;
  assign out_pc       = r_cur_pc;
  assign fault        = r_fault;

endmodule
